mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port.sv | 130 +++++++++++++
 tb/tb_mem_port.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// mem_port: turns controller read pulses and write levels into timed single-port RAM accesses.
// Define MEM_PORT_LAST_READ_EN to add a one-entry last-read buffer that answers repeated reads without touching the RAM.
module mem_port #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] addr,
    input  logic [31:0] fromCPU,
    input  logic        wRAM,
    input  logic        readstart,
    output logic [31:0] toCPU,
    output logic        readrdy,
    output logic        saverdy,
    output logic [14:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_DONE = 3'd2;
    localparam logic [2:0] S_WR_WAIT = 3'd3;
    localparam logic [2:0] S_WR_DONE = 3'd4;

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    logic [2:0] state;
    logic [3:0] cnt;
    logic       wr_armed;

`ifdef MEM_PORT_LAST_READ_EN
    logic [14:0] lr_tag;
    logic [31:0] lr_data;
    logic        lr_valid;
    logic        lr_hit;

    assign lr_hit = lr_valid && (addr == lr_tag);
`else
    logic [31:0] lr_data;
    logic        lr_hit;

    assign lr_hit  = 1'b0;
    assign lr_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            toCPU     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            wr_armed  <= 1'b1;
`ifdef MEM_PORT_LAST_READ_EN
            lr_tag    <= '0;
            lr_data   <= '0;
            lr_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Reads win over a simultaneous write; the write is picked up on the way back to idle.
                    if (readstart) begin
                        if (lr_hit) begin
                            toCPU <= lr_data;
                            state <= S_RD_DONE;
                        end else begin
                            ram_addr <= addr;
                            cnt      <= RD_CNT;
                            state    <= S_RD_WAIT;
                        end
                    end else if (wRAM && wr_armed) begin
                        ram_addr  <= addr;
                        ram_wdata <= fromCPU;
                        ram_we    <= 1'b1;
                        cnt       <= WR_CNT;
                        state     <= S_WR_WAIT;
`ifdef MEM_PORT_LAST_READ_EN
                        if (addr == lr_tag) begin
                            lr_valid <= 1'b0;
                        end
`endif
                    end
                end
                S_RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        toCPU <= ram_rdata;
                        state <= S_RD_DONE;
`ifdef MEM_PORT_LAST_READ_EN
                        lr_tag   <= ram_addr;
                        lr_data  <= ram_rdata;
                        lr_valid <= 1'b1;
`endif
                    end
                end
                S_RD_DONE: begin
                    state <= S_IDLE;
                end
                S_WR_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        ram_we <= 1'b0;
                        state  <= S_WR_DONE;
                    end
                end
                S_WR_DONE: begin
                    wr_armed <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A low wRAM re-arms in every state, so each high period yields exactly one write.
            if (!wRAM) begin
                wr_armed <= 1'b1;
            end
        end
    end

    assign readrdy = (state == S_RD_DONE);
    assign saverdy = (state == S_WR_DONE);

endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: table vectors, hand-written corner sequences and random traffic checked
// against a timestamp-based reference model of the port and a behavioural RAM.
module tb_mem_port;

    localparam int RDW  = 2;
    localparam int WRW  = 1;
    localparam int WRW3 = 3;
`ifdef MEM_PORT_LAST_READ_EN
    localparam bit HAS_LR  = 1'b1;
    localparam int HIT_LAT = 1;
`else
    localparam bit HAS_LR  = 1'b0;
    localparam int HIT_LAT = RDW + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] addr = '0;
    logic [31:0] fromCPU = '0;
    logic        wRAM = 1'b0;
    logic        readstart = 1'b0;
    logic [31:0] toCPU;
    logic        readrdy;
    logic        saverdy;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] w3_toCPU;
    logic        w3_readrdy;
    logic        w3_saverdy;
    logic [14:0] w3_ram_addr;
    logic [31:0] w3_ram_wdata;
    logic        w3_ram_we;
    logic [31:0] w3_ram_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU), .readrdy(readrdy), .saverdy(saverdy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    mem_port #(.RD_WAIT(RDW), .WR_WAIT(WRW3)) u_w3 (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(w3_toCPU), .readrdy(w3_readrdy), .saverdy(w3_saverdy),
        .ram_addr(w3_ram_addr), .ram_wdata(w3_ram_wdata), .ram_we(w3_ram_we), .ram_rdata(w3_ram_rdata)
    );

    assign w3_ram_rdata = 32'h5A5A_5A5A;

    // Behavioural RAM: data only becomes valid after the address has been stable long enough.
    logic [31:0] mem     [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic [14:0] prev_addr = '0;
    int          age = 0;

    assign ram_rdata = (ram_addr == prev_addr && age >= RDW - 1) ? mem[ram_addr] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_addr != prev_addr) age <= 1;
        else if (age < 100) age <= age + 1;
        prev_addr <= ram_addr;
    end

    // Reference model: each accepted access is turned into the cycle numbers of its events.
    int          m_idle_from, m_rr_at, m_sr_at, m_we_lo, m_we_hi, m_disarm_at, m_cap_at;
    logic [31:0] m_tc, m_wdata, m_cap_data, m_lr_data;
    logic [14:0] m_addr, m_cap_tag, m_lr_tag;
    bit          m_armed, m_lr_valid;

    task automatic model_step(input logic r, input logic rs, input logic w,
                              input logic [14:0] a, input logic [31:0] d, input int k);
        if (r) begin
            m_idle_from = k + 1; m_rr_at = -1; m_sr_at = -1; m_we_lo = 1; m_we_hi = 0;
            m_disarm_at = -1; m_cap_at = -1; m_tc = '0; m_addr = '0; m_wdata = '0;
            m_armed = 1'b1; m_lr_valid = 1'b0;
        end else begin
            if (k == m_cap_at) begin
                m_tc = m_cap_data; m_lr_tag = m_cap_tag; m_lr_data = m_cap_data; m_lr_valid = 1'b1;
            end
            if (k >= m_idle_from && rs) begin
                if (HAS_LR && m_lr_valid && a == m_lr_tag) begin
                    m_tc = m_lr_data; m_rr_at = k + 1; m_idle_from = k + 2;
                end else begin
                    m_addr = a; m_cap_at = k + RDW; m_cap_tag = a; m_cap_data = ref_mem[a];
                    m_rr_at = k + RDW + 1; m_idle_from = k + RDW + 2;
                end
            end else if (k >= m_idle_from && w && m_armed) begin
                m_addr = a; m_wdata = d; ref_mem[a] = d;
                m_we_lo = k + 1; m_we_hi = k + WRW; m_sr_at = k + WRW + 1;
                m_disarm_at = k + WRW + 1; m_idle_from = k + WRW + 2;
                if (a == m_lr_tag) m_lr_valid = 1'b0;
            end
            if (k == m_disarm_at) m_armed = 1'b0;
            if (!w) m_armed = 1'b1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("m_readrdy", 32'(readrdy), 32'(cyc == m_rr_at));
        checkOutput("m_saverdy", 32'(saverdy), 32'(cyc == m_sr_at));
        checkOutput("m_ram_we", 32'(ram_we), 32'(cyc >= m_we_lo && cyc <= m_we_hi));
        checkOutput("m_toCPU", toCPU, m_tc);
        checkOutput("m_ram_addr", 32'(ram_addr), 32'(m_addr));
        checkOutput("m_ram_wdata", ram_wdata, m_wdata);
    endtask

    task automatic applyStimulus(input logic r, input logic rs, input logic w,
                                 input logic [14:0] a, input logic [31:0] d);
        rst = r; readstart = rs; wRAM = w; addr = a; fromCPU = d;
        model_step(r, rs, w, a, d, cyc);
        @(posedge clk);
        #1;
        cyc++;
        checkModel();
    endtask

    task automatic measureRead(input string name, input logic [14:0] a,
                               input int exp_lat, input logic [31:0] exp_data);
        int lat;
        lat = -1;
        applyStimulus(1'b0, 1'b1, 1'b0, a, 32'h0);
        if (readrdy) lat = 1;
        for (int j = 1; j <= 20 && lat < 0; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, a, 32'h0);
            if (readrdy) lat = j + 1;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_data"}, toCPU, exp_data);
        applyStimulus(1'b0, 1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic doWrite(input logic [14:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        for (int j = 0; j < 20 && !done; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, a, d);
            if (saverdy) done = 1'b1;
        end
        checkOutput("write_done", 32'(done), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, a, d);
    endtask

    typedef struct {
        logic        r, rs, w;
        logic [14:0] a;
        logic [31:0] d;
        logic        rr, sr, we;
        logic [31:0] tc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rs, input logic w,
                                input logic [14:0] a, input logic [31:0] d,
                                input logic rr, input logic sr, input logic we, input logic [31:0] tc);
        vec_t v;
        v.r = r; v.rs = rs; v.w = w; v.a = a; v.d = d; v.rr = rr; v.sr = sr; v.we = we; v.tc = tc;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[$];
        logic [14:0] ra;
        logic        rw;

        for (int i = 0; i < 32768; i++) begin
            mem[i] <= 32'h5EED_0000 ^ {17'd0, 15'(i)} ^ {15'(i), 17'd0};
            ref_mem[i] = 32'h5EED_0000 ^ {17'd0, 15'(i)} ^ {15'(i), 17'd0};
        end
        mem[15'h0010] <= 32'hDEADBEEF; ref_mem[15'h0010] = 32'hDEADBEEF;
        mem[15'h0044] <= 32'hCAFE0044; ref_mem[15'h0044] = 32'hCAFE0044;
        mem[15'h0020] <= 32'h20202020; ref_mem[15'h0020] = 32'h20202020;

        //          rst   rs    w     addr      fromCPU        rr    sr    we    toCPU
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 15'h0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 15'h0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 15'h0010, 32'h0,         1'b1, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 15'h0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h1234, 32'h0000ABCD,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h1234, 32'h0000ABCD,  1'b0, 1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h1234, 32'h0000ABCD,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h1234, 32'h0000ABCD,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 15'h1234, 32'h0000ABCD,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 15'h0044, 32'h11112222,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h0044, 32'h11112222,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h0044, 32'h11112222,  1'b1, 1'b0, 1'b0, 32'hCAFE0044));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h0044, 32'h11112222,  1'b0, 1'b0, 1'b0, 32'hCAFE0044));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h0044, 32'h11112222,  1'b0, 1'b0, 1'b1, 32'hCAFE0044));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 15'h0044, 32'h11112222,  1'b0, 1'b1, 1'b0, 32'hCAFE0044));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 15'h0044, 32'h11112222,  1'b0, 1'b0, 1'b0, 32'hCAFE0044));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].rs, vecs[i].w, vecs[i].a, vecs[i].d);
            checkOutput($sformatf("tbl%0d_readrdy", i), 32'(readrdy), 32'(vecs[i].rr));
            checkOutput($sformatf("tbl%0d_saverdy", i), 32'(saverdy), 32'(vecs[i].sr));
            checkOutput($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            checkOutput($sformatf("tbl%0d_toCPU", i), toCPU, vecs[i].tc);
        end

        // Reset in the middle of a three-cycle write aborts it.
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 15'h0077, 32'h12345678);
        checkOutput("w3_we_first", 32'(w3_ram_we), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 15'h0077, 32'h12345678);
        checkOutput("w3_we_second", 32'(w3_ram_we), 32'd1);
        checkOutput("w3_saverdy_mid", 32'(w3_saverdy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0077, 32'h12345678);
        checkOutput("w3_we_after_rst", 32'(w3_ram_we), 32'd0);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 15'h0077, 32'h0);
            checkOutput($sformatf("w3_idle%0d_saverdy", j), 32'(w3_saverdy), 32'd0);
            checkOutput($sformatf("w3_idle%0d_we", j), 32'(w3_ram_we), 32'd0);
            checkOutput($sformatf("w3_idle%0d_toCPU", j), w3_toCPU, 32'h0);
        end

        // Repeated reads of one address, then a write to it invalidates any buffered copy.
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 32'h0);
        measureRead("rd20_first", 15'h0020, RDW + 1, 32'h20202020);
        measureRead("rd20_repeat", 15'h0020, HIT_LAT, 32'h20202020);
        doWrite(15'h0020, 32'h0BADF00D);
        measureRead("rd20_after_wr", 15'h0020, RDW + 1, 32'h0BADF00D);

        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0, 32'h0);
        rw = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5) == 0) rw = ~rw;
            case ($urandom_range(3))
                0: ra = 15'h0020;
                1: ra = 15'h0021;
                2: ra = 15'($urandom_range(63));
                default: ra = 15'($urandom);
            endcase
            applyStimulus($urandom_range(63) == 0, $urandom_range(3) == 0, rw, ra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
